lights_sequencer: RTL and testbench

- Controller that shares one dynamic LED lights unit between N_REQ requesters.
- Each requester asks for a target colour.
- The sequencer arbitrates round-robin, then drives the lights' button input with spaced single-cycle pulses until the colour feedback matches the target, then acknowledges.
- Sits between software/user-facing request logic and the lights block; it is the only driver of the lights' button.

---
 rtl/lights_pkg.sv | 26 ++
 rtl/lights_sequencer_rr_arbiter.sv | 29 ++
 rtl/lights_sequencer.sv | 137 +++++++++++++
 tb/tb_lights_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lights_pkg.sv
// Shared types and constants for the lights sequencer: colour range, step
// limit and the controller state encoding.
package lights_pkg;

  localparam int COLOUR_W = 3;

  typedef logic [COLOUR_W-1:0] colour_t;

  localparam colour_t COL_MIN   = 3'd1;
  localparam colour_t COL_MAX   = 3'd6;
  localparam int      MAX_STEPS = 6;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    GAP,
    PULSE,
    SETTLE,
    DONE
  } state_t;

  function automatic logic colour_valid(input colour_t c);
    return (c >= COL_MIN) && (c <= COL_MAX);
  endfunction

endpackage

// File: rtl/lights_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant_next,
  output logic             o_valid
);

  logic [PW:0] w_sum;

  always_comb begin
    o_grant_next = '0;
    o_valid      = 1'b0;
    w_sum        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(N_REQ)) w_sum = w_sum - (PW+1)'(N_REQ);
      if (!o_valid && i_req[w_sum[PW-1:0]]) begin
        o_grant_next[w_sum[PW-1:0]] = 1'b1;
        o_valid                     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lights_sequencer.sv
// Shares one LED lights unit between N_REQ requesters: round-robin grant, then
// spaced button pulses until colour_fb matches the target. LIGHTS_SEQ_TIMEOUT_EN
// adds a stuck-feedback abort after MAX_STEPS pulses.
module lights_sequencer
  import lights_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DWELL = 4,
  parameter int CW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [CW*N_REQ-1:0] target,
  input  logic [CW-1:0]       colour_fb,
  output logic                button,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    ack,
  output logic                err,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = $clog2(DWELL + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_err_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [PW-1:0]    w_pick_idx;
  colour_t          r_target;
  colour_t          w_pick_target;
  logic [DW-1:0]    r_dwell;
  logic [N_REQ-1:0] w_arb_grant;
  logic             w_arb_valid;
  logic             w_take;
`ifdef LIGHTS_SEQ_TIMEOUT_EN
  logic [2:0]       r_pulses;
`endif

  rr_arbiter #(
    .N_REQ(N_REQ),
    .PW   (PW)
  ) u_arb (
    .i_req       (req),
    .i_ptr       (r_ptr),
    .o_grant_next(w_arb_grant),
    .o_valid     (w_arb_valid)
  );

  assign w_take = (r_state == IDLE) && w_arb_valid;

  always_comb begin
    w_pick_idx    = '0;
    w_pick_target = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_pick_idx    = PW'(i);
        w_pick_target = target[i*CW +: CW];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE:   if (w_arb_valid) w_state_nxt = CHECK;
      CHECK: begin
        if (!colour_valid(r_target)) begin
          w_state_nxt = DONE;
          w_err_nxt   = 1'b1;
        end else if (colour_fb == r_target) begin
          w_state_nxt = DONE;
        end else begin
`ifdef LIGHTS_SEQ_TIMEOUT_EN
          // Feedback has not moved onto the target after a full colour cycle
          if (r_pulses == 3'(MAX_STEPS)) begin
            w_state_nxt = DONE;
            w_err_nxt   = 1'b1;
          end else
`endif
          w_state_nxt = GAP;
        end
      end
      GAP:    if (r_dwell == '0) w_state_nxt = PULSE;
      PULSE:  w_state_nxt = SETTLE;
      SETTLE: w_state_nxt = CHECK;
      DONE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_dwell <= '0;
      button  <= 1'b0;
      grant   <= '0;
      ack     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      button  <= (w_state_nxt == PULSE);
      busy    <= (w_state_nxt != IDLE);
      err     <= w_err_nxt;
      ack     <= (w_state_nxt == DONE) ? (N_REQ'(1) << r_owner) : '0;
      if (w_take) begin
        grant   <= w_arb_grant;
        r_owner <= w_pick_idx;
      end else if (w_state_nxt == DONE) begin
        grant <= '0;
        r_ptr <= (r_owner == PW'(N_REQ-1)) ? '0 : r_owner + PW'(1);
      end
      if (r_state == CHECK && w_state_nxt == GAP) r_dwell <= DW'(DWELL-1);
      else if (r_state == GAP && r_dwell != '0)  r_dwell <= r_dwell - DW'(1);
    end
  end

`ifdef LIGHTS_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_pulses <= '0;
    else if (w_take)           r_pulses <= '0;
    else if (r_state == PULSE) r_pulses <= r_pulses + 3'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (w_take) r_target <= w_pick_target;
  end

endmodule

// File: tb/tb_lights_sequencer.sv
// Directed bench for lights_sequencer with a behavioural lights-unit model;
// timeout checks depend on LIGHTS_SEQ_TIMEOUT_EN.
module tb_lights_sequencer;

  localparam int N_REQ = 3;
  localparam int DWELL = 4;
  localparam int CW    = 3;
  localparam int STEP  = DWELL + 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req = '0;
  logic [CW*N_REQ-1:0] target = '0;
  logic [CW-1:0]       colour_fb;
  logic                button;
  logic [N_REQ-1:0]    grant, ack;
  logic                err, busy;

  logic [2:0] col = 3'd1;
  logic [2:0] col_set = 3'd1;
  logic       col_load = 1'b0;
  logic       stuck = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  lights_sequencer #(.N_REQ(N_REQ), .DWELL(DWELL), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .target(target), .colour_fb(colour_fb),
    .button(button), .grant(grant), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign colour_fb = col;

  // Lights unit: 1..5 step up, 6 wraps to 1, out-of-range recovers to 1
  always @(posedge clk) begin
    if (col_load) col <= col_set;
    else if (button && !stuck) col <= (col >= 3'd1 && col <= 3'd5) ? col + 3'd1 : 3'd1;
  end

  typedef struct {
    logic [2:0] rq;
    logic [8:0] tg;
    logic [2:0] c0;
    int         ack_cyc;
    int         pulses;
    int         e;
    int         cfin;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_colour(input logic [2:0] c);
    @(negedge clk);
    col_set  = c;
    col_load = 1'b1;
    @(negedge clk);
    col_load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_txn(input logic [2:0] rq, input logic [8:0] tg, input logic [2:0] c0,
                         input int limit, output int ack_cyc, output int ack_val,
                         output int err_v, output int pulses, output int grant1);
    int   last_pulse;
    int   viol;
    logic prev_btn;
    set_colour(c0);
    req = rq;
    target = tg;
    ack_cyc = -1; ack_val = 0; err_v = 0; pulses = 0; grant1 = 0;
    last_pulse = -100; viol = 0; prev_btn = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) grant1 = int'(grant);
      if (button) begin
        if (prev_btn || (pulses > 0 && (n - last_pulse) < STEP)) viol++;
        pulses++;
        last_pulse = n;
      end
      if (err && ack == '0) viol++;
      prev_btn = button;
      if (ack != '0) begin
        ack_cyc = n;
        ack_val = int'(ack);
        err_v   = int'(err);
        check("grant_in_done", int'(grant), 0);
        req = '0;
        break;
      end
    end
    if (ack_cyc < 0) req = '0;
    check("pulse_rules", viol, 0);
    @(negedge clk);
    check("idle_after_ack", int'({busy, button, ack}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac, av, ev, pc, g1;
    int k;
    int cyc[4];
    int val[4];
    int acks;

    vecs[0] = '{3'b001, 9'b000_000_001, 3'd1, 2,  0, 0, 1};
    vecs[1] = '{3'b010, 9'b000_011_000, 3'd1, 16, 2, 0, 3};
    vecs[2] = '{3'b001, 9'b000_000_010, 3'd5, 23, 3, 0, 2};
    vecs[3] = '{3'b001, 9'b000_000_111, 3'd4, 2,  0, 1, 4};
    vecs[4] = '{3'b100, 9'b000_000_000, 3'd3, 2,  0, 1, 3};
    vecs[5] = '{3'b100, 9'b001_000_000, 3'd0, 9,  1, 0, 1};
    vecs[6] = '{3'b010, 9'b000_011_000, 3'd7, 23, 3, 0, 3};
    vecs[7] = '{3'b001, 9'b000_000_001, 3'd2, 37, 5, 0, 1};

    repeat (2) @(negedge clk);
    check("reset_outputs", int'({button, grant, ack, err, busy}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_release", int'({button, grant, ack, err, busy}), 0);

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].rq, vecs[v].tg, vecs[v].c0, 60, ac, av, ev, pc, g1);
      check($sformatf("v%0d_grant", v), g1, int'(vecs[v].rq));
      check($sformatf("v%0d_ack_cycle", v), ac, vecs[v].ack_cyc);
      check($sformatf("v%0d_ack_owner", v), av, int'(vecs[v].rq));
      check($sformatf("v%0d_err", v), ev, vecs[v].e);
      check($sformatf("v%0d_pulses", v), pc, vecs[v].pulses);
      check($sformatf("v%0d_colour", v), int'(col), vecs[v].cfin);
    end

    // Round robin from pointer 0 with all three requests held
    do_reset();
    set_colour(3'd1);
    req = 3'b111;
    target = 9'b001_001_001;
    k = 0;
    for (int n = 1; n <= 20 && k < 4; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        cyc[k] = n;
        val[k] = int'(ack);
        k++;
        if (k == 4) req = '0;
      end
    end
    req = '0;
    check("rr_ack_count", k, 4);
    if (k == 4) begin
      check("rr_ack0", val[0], 1);
      check("rr_ack1", val[1], 2);
      check("rr_ack2", val[2], 4);
      check("rr_ack3", val[3], 1);
      check("rr_cyc0", cyc[0], 2);
      check("rr_cyc1", cyc[1], 5);
      check("rr_cyc2", cyc[2], 8);
      check("rr_cyc3", cyc[3], 11);
    end
    repeat (2) @(negedge clk);

    // Target change and req drop after grant are ignored
    set_colour(3'd1);
    req = 3'b010;
    target = 9'b000_011_000;
    repeat (3) @(negedge clk);
    target = 9'b000_110_000;
    req = '0;
    ac = -1;
    for (int n = 4; n <= 40; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        ac = n;
        av = int'(ack);
        ev = int'(err);
        break;
      end
    end
    check("latch_ack_cycle", ac, 16);
    check("latch_ack_owner", av, 2);
    check("latch_err", ev, 0);
    check("latch_colour", int'(col), 3);
    @(negedge clk);

    // Owner 0 completes so the pointer moves to 1
    run_txn(3'b001, 9'b000_000_001, 3'd1, 20, ac, av, ev, pc, g1);
    check("ptr_setup_ack", av, 1);

    // Asynchronous reset during GAP of a 4-step request
    set_colour(3'd1);
    req = 3'b100;
    target = 9'b101_000_000;
    repeat (3) @(negedge clk);
    check("pre_reset_grant", int'(grant), 4);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", int'({button, grant, ack, err, busy}), 0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    check("no_ack_after_reset", acks, 0);
    req = 3'b011;
    target = 9'b000_001_001;
    @(negedge clk);
    check("post_reset_grant", int'(grant), 1);
    @(negedge clk);
    check("post_reset_ack", int'(ack), 1);
    req = '0;
    repeat (2) @(negedge clk);

`ifdef LIGHTS_SEQ_TIMEOUT_EN
    stuck = 1'b1;
    run_txn(3'b001, 9'b000_000_010, 3'd4, 80, ac, av, ev, pc, g1);
    check("timeout_ack_cycle", ac, 2 + 6*STEP);
    check("timeout_err", ev, 1);
    check("timeout_pulses", pc, 6);
    stuck = 1'b0;
`else
    set_colour(3'd4);
    stuck = 1'b1;
    req = 3'b001;
    target = 9'b000_000_010;
    acks = 0;
    pc = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ack != '0) acks++;
      if (button) pc++;
    end
    check("stuck_no_ack", acks, 0);
    check("stuck_pulses", pc, 8);
    req = '0;
    stuck = 1'b0;
    do_reset();
    @(negedge clk);
    check("stuck_cleared", int'(busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
